// File: rtl/proc_pkg.sv
// proc_pkg: shared state/opcode types and flag bit positions for proc_core
package proc_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK} proc_state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_MUL, OP_CMP, OP_RSH, OP_LSH, OP_LOAD, OP_STORE,
    OP_JMP, OP_JE, OP_JG, OP_JL, OP_SUB, OP_AND, OP_OR, OP_XOR
  } opcode_t;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_G = 2;
  localparam int FLAG_L = 3;
endpackage

// File: rtl/proc_regfile.sv
// proc_regfile: register file, two async read ports, one sync write port
module proc_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS = 4,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] regs [NREGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '{default: '0};
    else if (we) regs[waddr] <= wdata;
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/proc_core.sv
// proc_core: parametrised multi-cycle core, FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Define PROC_EXT_OPS_EN to enable SUB/AND/OR/XOR on opcodes 12-15.
module proc_core
  import proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS = 4,
  parameter int PC_W = 8,
  parameter int MEM_DEPTH = 16,
  localparam int REG_AW = $clog2(NREGS),
  localparam int MEM_AW = $clog2(MEM_DEPTH),
  localparam int SH_W = $clog2(DATA_W),
  localparam int INSTR_W = 4 + 2*REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [DATA_W-1:0]  proc_out,
  output logic [3:0]         proc_flags,
  output logic               retire,
  output logic               illegal
);
  proc_state_t state, state_n;
  opcode_t op;
  logic [INSTR_W-1:0] ir;
  logic [REG_AW-1:0] rd, rs;
  logic [DATA_W-1:0] imm, a, b, rf_a, rf_b, res, res_q, mem_q, wb_data;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [3:0] flg, flg_q;
  logic wr, wr_q, ill, ill_q, taken;
  logic [PC_W-1:0] pc_q;
  logic [DATA_W:0] sum;
  logic [2*DATA_W-1:0] prod;
  assign op = opcode_t'(ir[INSTR_W-1 -: 4]);
  assign rd = ir[DATA_W+2*REG_AW-1 -: REG_AW];
  assign rs = ir[DATA_W+REG_AW-1 -: REG_AW];
  assign imm = ir[DATA_W-1:0];
  assign instr_ready = state == S_FETCH;
  assign sum = {1'b0, a} + {1'b0, b};
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign wb_data = op == OP_LOAD ? mem_q : res_q;
  assign taken = op == OP_JMP || (op == OP_JE && proc_flags[FLAG_Z]) ||
                 (op == OP_JG && proc_flags[FLAG_G]) || (op == OP_JL && proc_flags[FLAG_L]);
`ifdef PROC_EXT_OPS_EN
  logic [DATA_W:0] diff;
  assign diff = {1'b0, a} - {1'b0, b};
`endif
  proc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk(clk), .rst_n(rst_n), .we(state == S_WRITEBACK && wr_q), .waddr(rd), .wdata(wb_data),
    .raddr_a(rd), .rdata_a(rf_a), .raddr_b(rs), .rdata_b(rf_b)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:     state_n = instr_valid ? S_DECODE : S_FETCH;
      S_DECODE:    state_n = S_EXECUTE;
      S_EXECUTE:   state_n = op == OP_LOAD ? S_MEM : S_WRITEBACK;
      S_MEM:       state_n = S_WRITEBACK;
      default:     state_n = S_FETCH;
    endcase
  end
  always_comb begin
    res = '0;
    flg = proc_flags;
    wr = 1'b0;
    ill = 1'b0;
    case (op)
      OP_ADD: begin {flg[FLAG_C], res} = sum; wr = 1'b1; end
      OP_MUL: begin res = prod[DATA_W-1:0]; flg[FLAG_C] = |prod[2*DATA_W-1:DATA_W]; wr = 1'b1; end
      OP_CMP: begin
        flg[FLAG_Z] = a == b;
        flg[FLAG_G] = a > b;
        flg[FLAG_L] = a < b;
        flg[FLAG_C] = 1'b0;
      end
      OP_RSH: begin res = a >> imm[SH_W-1:0]; flg[FLAG_C] = 1'b0; wr = 1'b1; end
      OP_LSH: begin res = a << imm[SH_W-1:0]; flg[FLAG_C] = 1'b0; wr = 1'b1; end
      OP_LOAD: wr = 1'b1;
      OP_NOP, OP_STORE, OP_JMP, OP_JE, OP_JG, OP_JL: ;
`ifdef PROC_EXT_OPS_EN
      OP_SUB: begin {flg[FLAG_C], res} = diff; wr = 1'b1; end
      OP_AND: begin res = a & b; flg[FLAG_C] = 1'b0; wr = 1'b1; end
      OP_OR:  begin res = a | b; flg[FLAG_C] = 1'b0; wr = 1'b1; end
      OP_XOR: begin res = a ^ b; flg[FLAG_C] = 1'b0; wr = 1'b1; end
`endif
      default: ill = 1'b1;
    endcase
    // LOAD holds flags; its result is only known after MEM
    if (wr && op != OP_LOAD) flg[FLAG_Z] = ~|res;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_FETCH;
      ir <= '0;
      a <= '0;
      b <= '0;
      res_q <= '0;
      flg_q <= '0;
      wr_q <= 1'b0;
      ill_q <= 1'b0;
      pc_q <= '0;
      pc <= '0;
      proc_flags <= '0;
      proc_out <= '0;
      retire <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      retire <= state == S_WRITEBACK;
      illegal <= state == S_WRITEBACK && ill_q;
      if (instr_valid && instr_ready) ir <= instr;
      if (state == S_DECODE) begin
        a <= rf_a;
        b <= rf_b;
      end
      if (state == S_EXECUTE) begin
        res_q <= res;
        flg_q <= flg;
        wr_q <= wr;
        ill_q <= ill;
        pc_q <= taken ? PC_W'(imm) : pc + PC_W'(1);
      end
      if (state == S_WRITEBACK) begin
        proc_flags <= flg_q;
        pc <= pc_q;
        if (wr_q) proc_out <= wb_data;
      end
    end
  // data memory is deliberately not reset
  always_ff @(posedge clk) begin
    if (state == S_MEM) mem_q <= mem[imm[MEM_AW-1:0]];
    if (state == S_WRITEBACK && op == OP_STORE) mem[imm[MEM_AW-1:0]] <= a;
  end
endmodule

// File: doc/proc_core.md
# proc_core

Parametrised multi-cycle processor core, the successor to the fixed 4-bit processor. It adds configurable data width, register count, PC width and data-memory depth, and accepts instructions over a valid/ready handshake. It executes the shared opcode set (arithmetic, compare, shifts, load/store, conditional jumps) through a FETCH→DECODE→EXECUTE→(MEM)→WRITEBACK state machine. It sits between an external instruction source indexed by `pc` and the system's result/flag observers.

## Interface
- `DATA_W`, 8: datapath, register and memory word width (≥4).
- `NREGS`, 4: register count (power of two, ≥2); `REG_AW = $clog2(NREGS)`.
- `PC_W`, 8: program counter width.
- `MEM_DEPTH`, 16: data memory words (power of two); `MEM_AW = $clog2(MEM_DEPTH)`.
- Derived: `INSTR_W = 4 + 2*REG_AW + DATA_W`. Fields, MSB first: `opcode[3:0]`, `rd`, `rs`, `imm[DATA_W-1:0]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_valid` in 1: `instr` is valid.
- `instr_ready` out 1: core accepts an instruction this cycle.
- `instr` in INSTR_W: instruction word.
- `pc` out PC_W: address of the next instruction to fetch.
- `proc_out` out DATA_W: last value written to a register.
- `proc_flags` out 4: [0]=Z, [1]=C, [2]=G, [3]=L.
- `retire` out 1: one-cycle pulse per completed instruction.
- `illegal` out 1: one-cycle pulse, coincident with `retire`, when the retired opcode was illegal.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- FETCH: `instr_ready`=1. On `instr_valid && instr_ready`, latch `instr` into the instruction register and go to DECODE. Otherwise stay in FETCH.
- DECODE: read `rd` and `rs` into the operand latches A and B. Go to EXECUTE.
- EXECUTE: compute the result and new flags. LOAD goes to MEM. Every other opcode goes to WRITEBACK.
- MEM: synchronous read of `mem[imm[MEM_AW-1:0]]`. Go to WRITEBACK.
- WRITEBACK: commit the effects and go to FETCH.
- Opcodes:
  - NOP=0: no state change.
  - ADD=1: rd←A+B. Z from result. C=carry out of bit DATA_W-1.
  - MUL=2: rd←low DATA_W bits of A*B. Z from result. C=OR of the upper DATA_W product bits.
  - CMP=3: Z=(A==B), G=(A>B), L=(A<B), unsigned. C←0. No register write.
  - RSH=4, LSH=5: rd←A shifted logically by `imm[$clog2(DATA_W)-1:0]`. Z from result. C←0.
  - LOAD=6: rd←mem word.
  - STORE=7: mem[imm[MEM_AW-1:0]]←A.
  - JMP=8: pc←imm[PC_W-1:0], zero-extended if PC_W>DATA_W.
  - JE=9, JG=10, JL=11: jump as JMP if Z, G or L respectively is set. Otherwise pc←pc+1.
  - 12–15: illegal unless PROC_EXT_OPS_EN is defined. Illegal opcodes execute as NOP and pulse `illegal`.
- Flag updates:
  - ADD, MUL and shifts update only Z and C; G and L are held.
  - CMP updates all four flags.
  - LOAD, STORE, NOP and jumps hold all flags.
- `proc_out` updates only when a register is written.
- pc←pc+1, modulo 2^PC_W, for every non-taken instruction. PC_W'(2^PC_W−1)+1 wraps to 0.
- `rd==rs` is legal; A and B are both that register's value.
- Memory contents are not reset. A LOAD from a never-written address returns an undefined value.

## Timing
- Reset (async assert): state=FETCH, pc=0, registers=0, `proc_flags`=0, `proc_out`=0, `retire`=0, `illegal`=0, `instr_ready`=1 one cycle after release. Any in-flight instruction is discarded with no register or memory write.
- Latency from the accept edge to the WRITEBACK edge: 3 cycles for non-LOAD, 4 cycles for LOAD. `retire` is high in the cycle after the WRITEBACK edge.
- Registers, memory, `proc_flags`, `proc_out` and `pc` all update on the WRITEBACK edge and are visible together with `retire`.
- The next accept can happen at the earliest in the cycle `retire` is high. This gives a throughput of 4 cycles per instruction (5 for LOAD) with `instr_valid` held high.
- `instr_ready` is low in every state except FETCH. The source must hold `instr` stable while `instr_valid` is high and the instruction has not been accepted.

## Configuration
- `PROC_EXT_OPS_EN` defined: opcodes 12=SUB (rd←A−B, C=borrow), 13=AND, 14=OR, 15=XOR (rd←A op B). All four update Z from the result and write C; SUB writes the borrow, AND/OR/XOR clear C to 0. None of them pulse `illegal`.
- Not defined: opcodes 12–15 behave as NOP with an `illegal` pulse, and the SUB/AND/OR/XOR logic is absent.

## Structure
- `proc_pkg`: `proc_state_t` enum, `opcode_t` enum (values 0–15), flag bit index constants (`FLAG_Z`, `FLAG_C`, `FLAG_G`, `FLAG_L`).
- Sub-module `proc_regfile #(DATA_W, NREGS)`:
  - Two asynchronous read ports and one synchronous write port.
  - Reset to 0 on `rst_n`.
- ALU, data memory and FSM live inline in `proc_core`.

## Test plan
All scenarios use DATA_W=8, NREGS=4, PC_W=8, MEM_DEPTH=16.
- Reset mid-EXECUTE of ADD r0,r0: no write occurs, pc=0, `proc_flags`=0, FETCH is entered with `instr_ready`=1.
- r1=200, r2=100 (via LOAD), ADD r1,r2 → `proc_out`=44, Z=0, C=1, pc incremented, `retire` pulse 4 cycles after accept.
- STORE r1→mem[3], then LOAD r3←mem[3] → `proc_out`=r1 value. The LOAD's `retire` comes 5 cycles after its accept.
- CMP r0,r1 with r0=5, r1=9 → L=1, G=0, Z=0. JL imm=0x40 → pc=0x40. JG imm=0x10 → pc=0x41.
- MUL 16×16 → `proc_out`=0, Z=1, C=1. LSH r, imm=3 on 0x81 → 0x08.
- Opcode 13 with r0=0x0F, r1=0x3C: without macro → `illegal` pulse, registers unchanged. With macro → `proc_out`=0x0C, `illegal`=0.
- `instr_valid` toggled randomly with `instr` held stable → each instruction is accepted exactly once. pc=0xFF non-jump → pc wraps to 0x00.
